piso_tx: RTL
============

Name: piso_tx

Overview:
- Parallel-in serial-out transmitter: accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out one bit per clock on a serial line, with a qualifying valid strobe.
- Serves as the transmit end of the team's shift-register datapath family; pairs with a serial-in receiver that reassembles the word.
- Provides a done pulse and busy flag for upstream sequencing.

Parameters:
- WIDTH, 4, number of data bits per word (≥2).
- MSB_FIRST, 1, 1 = bit WIDTH-1 transmitted first; 0 = bit 0 first.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- din  input  WIDTH  parallel word to transmit.
- load_valid  input  1  din valid; word accepted when load_valid && load_ready at posedge clk.
- load_ready  output  1  combinational, 1 iff state == IDLE.
- sout  output  1  serial data, registered.
- sout_valid  output  1  registered, 1 while sout carries a frame bit.
- busy  output  1  registered, 1 from the cycle after accept through the last frame bit.
- done  output  1  registered, one-cycle pulse coincident with the last frame bit.

Behaviour:
- Reset: state=IDLE, shift reg=0, bit counter=0, sout=0, sout_valid=0, busy=0, done=0. load_ready=1 during and after reset (state is IDLE).
- States: IDLE, SHIFT, PAR (PAR exists only with PIPO_TX_PARITY_EN).
- IDLE: load_ready=1, sout=0, sout_valid=0. On accept at edge N: capture din, counter=0, go to SHIFT. First data bit appears on sout with sout_valid=1 in the cycle after edge N (1-cycle latency).
- SHIFT: one bit per cycle for exactly WIDTH cycles. Order is per MSB_FIRST. Counter runs 0..WIDTH-1.
  - Without parity: done=1 with bit WIDTH-1; next state IDLE.
  - With parity: next state PAR; done stays 0.
- PAR: sout=even-parity bit (XOR of all captured bits), sout_valid=1, done=1 for that cycle; next state IDLE.
- Frame length: WIDTH cycles, or WIDTH+1 with parity.
- load_valid while not IDLE: ignored, no capture. din changes during shifting do not affect the transmitted word.
- Back-to-back: load_ready returns the cycle after the last frame bit. A word accepted then starts its first bit on the following cycle, giving exactly one idle cycle (sout_valid=0) between frames.
- Reset mid-frame: immediate return to reset values. The partial frame is discarded, and no done pulse is produced.
- Counter width: $clog2(WIDTH) bits plus 1 guard bit; no wrap-around during a frame.

Optional Feature:
- Macro PIPO_TX_PARITY_EN.
- Defined: PAR state is compiled in; each frame appends one even-parity bit after the data bits, and done moves to the parity cycle.
- Undefined: PAR state and parity logic are absent; frame is WIDTH bits, and done is coincident with the last data bit.

Test Plan (WIDTH=4):
- MSB_FIRST=1, no parity: rst high then low at t=1; load 4'b1110 at edge 1 → sout 1,1,1,0 on cycles 2–5 with sout_valid=1; done=1 only in cycle 5; busy low from cycle 6; load_ready=1 in cycle 6.
- MSB_FIRST=0, no parity: load 4'b1110 → sout 0,1,1,1; done on the 4th bit.
- PIPO_TX_PARITY_EN defined: load 4'b1110 → sout 1,1,1,0 then parity 1; sout_valid high for 5 cycles; done on the parity cycle. Load 4'b0011 → parity bit 0.
- Busy-load rejection: load 4'b1010, then assert load_valid with din=4'b0101 during cycle 3 → load_ready=0, transmitted bits remain 1,0,1,0, no second frame starts.
- Back-to-back: hold load_valid=1 with din=4'b1010 then 4'b0011 → frames 1,0,1,0 and 0,0,1,1 separated by exactly one sout_valid=0 cycle.
- Reset mid-frame: assert rst after the 2nd bit of 4'b1110 → sout=0, sout_valid=0, busy=0, done never pulses, load_ready=1. A new load of 4'b0001 after release transmits correctly as 0,0,0,1.

Source files
------------

// File: rtl/piso_tx_if.sv
// Load handshake and serial output bundle for piso_tx.
// master = upstream word source / serial sink side, slave = the transmitter.
interface piso_tx_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

  modport master (
    output din,
    output load_valid,
    input  load_ready,
    input  sout,
    input  sout_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  din,
    input  load_valid,
    output load_ready,
    output sout,
    output sout_valid,
    output busy,
    output done
  );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: one WIDTH-bit word per frame, one bit per clock.
// Define PIPO_TX_PARITY_EN to append an even-parity bit (done then marks the parity cycle).
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  piso_tx_if.slave tx
);
  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifndef PIPO_TX_PARITY_EN
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);
`endif

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
`ifdef PIPO_TX_PARITY_EN
  localparam logic [1:0] PAR   = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef PIPO_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Drops the bit just placed on sout so the next one sits at the output end.
  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

`ifdef PIPO_TX_PARITY_EN
  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction
`endif

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    sout_d       = 1'b0;
    sout_valid_d = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
`ifdef PIPO_TX_PARITY_EN
    par_d        = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (tx.load_valid) begin
          state_d      = SHIFT;
          cnt_d        = {CW{1'b0}};
          sout_d       = first_bit(tx.din);
          shreg_d      = shift_out(tx.din);
          sout_valid_d = 1'b1;
          busy_d       = 1'b1;
`ifdef PIPO_TX_PARITY_EN
          par_d        = even_parity(tx.din);
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // cnt_q is the index of the bit currently on sout.
        if (cnt_q == LAST) begin
`ifdef PIPO_TX_PARITY_EN
          state_d      = PAR;
          sout_d       = par_q;
          sout_valid_d = 1'b1;
          busy_d       = 1'b1;
          done_d       = 1'b1;
`else
          state_d      = IDLE;
`endif
        end else begin
          cnt_d        = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          sout_d       = first_bit(shreg_q);
          shreg_d      = shift_out(shreg_q);
          sout_valid_d = 1'b1;
          busy_d       = 1'b1;
`ifndef PIPO_TX_PARITY_EN
          done_d       = (cnt_q == PENULT);
`endif
        end
      end
`ifdef PIPO_TX_PARITY_EN
      PAR: begin
        state_d = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= {WIDTH{1'b0}};
      cnt_q        <= {CW{1'b0}};
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef PIPO_TX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef PIPO_TX_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign tx.load_ready = (state_q == IDLE);
  assign tx.sout       = sout_q;
  assign tx.sout_valid = sout_valid_q;
  assign tx.busy       = busy_q;
  assign tx.done       = done_q;
endmodule
